// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the 7-segment scan controller.
//   SEG_BLANK : all segments and the decimal point off (active-low).
//   HEX_SEG   : hex nibble to segment pattern, bits 0..6 = a..g, bit 7 = dp,
//               active-low, dp off. Index 15 is leftmost in the literal.
package seg_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [15:0][7:0] HEX_SEG = {
      8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
      8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
      8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
      8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
   };

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational nibble + decimal point to active-low
// segment pattern.
//   nib_i : hex digit value
//   dp_i  : 1 = decimal point lit
//   seg_o : segments a..g in bits 0..6, dp in bit 7, active-low
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       dp_i,
   output logic [7:0] seg_o
);

   assign seg_o = {~dp_i, HEX_SEG[nib_i][6:0]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment display scanner with double-buffered
// data, PWM brightness, leading-zero blanking and per-digit blink.
//   clk, clr_n    : clock, asynchronous active-low reset
//   data, dp      : nibble / decimal point per digit (digit DIGITS-1 is MSD)
//   load          : strobe capturing data/dp into the pending buffer
//   digit_mask    : 1 = digit in use
//   blink_mask    : 1 = digit blinks
//   blank_lz      : leading-zero blanking enable
//   brightness    : PWM on-phases per slot
//   display_data  : registered active-low segments (dp in bit 7)
//   display_en    : registered one-cold digit enable
//   frame_done    : pulse in the last cycle of each full scan
//   upd_pending   : pending buffer waiting for the next frame boundary
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int SCAN_DIV     = 100000,
   parameter int BRIGHT_W     = 4,
   parameter int BLINK_FRAMES = 256
) (
   input  logic                  clk,
   input  logic                  clr_n,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  load,
   input  logic [DIGITS-1:0]     digit_mask,
   input  logic [DIGITS-1:0]     blink_mask,
   input  logic                  blank_lz,
   input  logic [BRIGHT_W-1:0]   brightness,
   output logic [7:0]            display_data,
   output logic [DIGITS-1:0]     display_en,
   output logic                  frame_done,
   output logic                  upd_pending
);

   // The slot tick is kept as (phase, sub) so the PWM phase needs no divider:
   // tick = phase * UNIT + sub.
   localparam int UNIT  = SCAN_DIV >> BRIGHT_W;
   localparam int SUB_W = (UNIT > 1) ? $clog2(UNIT) : 1;
   localparam int DIG_W = $clog2(DIGITS);
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(UNIT - 1);
   localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

   logic [SUB_W-1:0]          sub_q, sub_d;
   logic [BRIGHT_W-1:0]       phase_q, phase_d;
   logic [DIG_W-1:0]          digit_q, digit_d;
   logic [FRM_W-1:0]          frm_q, frm_d;
   logic                      blink_q, blink_d;
   logic [DIGITS-1:0][3:0]    act_nib_q, act_nib_d, pend_nib_q, pend_nib_d;
   logic [DIGITS-1:0]         act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic                      upd_q, upd_d;
   logic                      fd_q, fd_d;
   logic [DIGITS-1:0]         en_q, en_d;
   logic [7:0]                seg_q, seg_d;

   logic                      slot_end, frame_end, upper_nz, blank;
   logic [3:0]                cur_nib;
   logic                      cur_dp;
   logic [7:0]                dec_seg;

   assign cur_nib = act_nib_q[digit_q];
   assign cur_dp  = act_dp_q[digit_q];

   seg_hex_decode u_dec (
      .nib_i (cur_nib),
      .dp_i  (cur_dp),
      .seg_o (dec_seg)
   );

   always_comb begin
      slot_end  = (sub_q == SUB_LAST) && (phase_q == '1);
      frame_end = slot_end && (digit_q == DIG_LAST);

      // scan counters; phase wraps on its own at the end of the slot
      sub_d   = (sub_q == SUB_LAST) ? '0 : sub_q + 1'b1;
      phase_d = (sub_q == SUB_LAST) ? phase_q + 1'b1 : phase_q;
      digit_d = digit_q;
      if (slot_end) digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;

      // frame_done is registered from next state so it is high in the
      // boundary cycle itself, the same cycle a coincident load must hit
      fd_d = (sub_d == SUB_LAST) && (phase_d == '1) && (digit_d == DIG_LAST);

      frm_d   = frm_q;
      blink_d = blink_q;
      if (frame_end) begin
         if (frm_q == FRM_LAST) begin
            frm_d   = '0;
            blink_d = ~blink_q;
         end else begin
            frm_d = frm_q + 1'b1;
         end
      end

      // double buffer: a load on the boundary bypasses pending entirely
      pend_nib_d = load ? data : pend_nib_q;
      pend_dp_d  = load ? dp   : pend_dp_q;
      act_nib_d  = act_nib_q;
      act_dp_d   = act_dp_q;
      upd_d      = upd_q;
      if (frame_end) begin
         upd_d = 1'b0;
         if (load) begin
            act_nib_d = data;
            act_dp_d  = dp;
         end else if (upd_q) begin
            act_nib_d = pend_nib_q;
            act_dp_d  = pend_dp_q;
         end
      end else if (load) begin
         upd_d = 1'b1;
      end

      // any non-zero nibble at or above the current digit keeps it lit
      upper_nz = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (i >= int'(digit_q) && act_nib_q[i] != 4'h0) upper_nz = 1'b1;

      blank = !digit_mask[digit_q]
           || (blank_lz && digit_q != '0 && !upper_nz)
           || (blink_mask[digit_q] && blink_q)
           || (phase_q >= brightness);

      en_d  = '1;
      seg_d = SEG_BLANK;
      if (!blank) begin
         en_d[digit_q] = 1'b0;
         seg_d         = dec_seg;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sub_q      <= '0;
         phase_q    <= '0;
         digit_q    <= '0;
         frm_q      <= '0;
         blink_q    <= 1'b0;
         act_nib_q  <= '0;
         act_dp_q   <= '0;
         pend_nib_q <= '0;
         pend_dp_q  <= '0;
         upd_q      <= 1'b0;
         fd_q       <= 1'b0;
         en_q       <= '1;
         seg_q      <= SEG_BLANK;
      end else begin
         sub_q      <= sub_d;
         phase_q    <= phase_d;
         digit_q    <= digit_d;
         frm_q      <= frm_d;
         blink_q    <= blink_d;
         act_nib_q  <= act_nib_d;
         act_dp_q   <= act_dp_d;
         pend_nib_q <= pend_nib_d;
         pend_dp_q  <= pend_dp_d;
         upd_q      <= upd_d;
         fd_q       <= fd_d;
         en_q       <= en_d;
         seg_q      <= seg_d;
      end
   end

   assign display_data = seg_q;
   assign display_en   = en_q;
   assign frame_done   = fd_q;
   assign upd_pending  = upd_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed digits, 2..16.
REQ-002 Parameter SCAN_DIV, default 100000: clk cycles per digit slot; multiple of 2**BRIGHT_W.
REQ-003 Parameter BRIGHT_W, default 4: brightness control width.
REQ-004 Parameter BLINK_FRAMES, default 256: frames per blink half-period, >=1.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 clr_n  in  1  asynchronous, active-low reset.
REQ-007 data  in  4*DIGITS  hex nibble per digit; nibble i drives digit i, digit DIGITS-1 most significant.
REQ-008 dp  in  DIGITS  decimal point per digit, 1 = lit.
REQ-009 load  in  1  single-cycle strobe; captures data and dp into pending buffer.
REQ-010 digit_mask  in  DIGITS  1 = digit in use; 0 = permanently blank.
REQ-011 blink_mask  in  DIGITS  1 = digit blinks.
REQ-012 blank_lz  in  1  1 = leading-zero blanking on.
REQ-013 brightness  in  BRIGHT_W  on-phases per slot, 0 = dark.
REQ-014 display_data  out  8  segments a..g in bits 0..6, dp bit 7, active-low, registered.
REQ-015 display_en  out  DIGITS  one-cold digit enable, active-low, registered.
REQ-016 frame_done  out  1  one-cycle pulse at end of each full scan.
REQ-017 upd_pending  out  1  pending buffer not yet applied.

Function
REQ-018 tick_cnt counts 0..SCAN_DIV-1, wraps to 0; digit index advances on wrap, DIGITS-1 -> 0.
REQ-019 frame_done SHALL assert in the cycle digit index wraps DIGITS-1 -> 0.
REQ-020 load captures data/dp into pending and sets upd_pending; later load before transfer overwrites pending.
REQ-021 Pending copies to active only at frame boundary (frame_done cycle); upd_pending clears there.
REQ-022 load coincident with frame boundary: new value goes directly to active, upd_pending stays 0.
REQ-023 Output for a slot derives from active buffer only; no mid-frame tearing.
REQ-024 PWM phase = tick_cnt / (SCAN_DIV >> BRIGHT_W); digit enabled while phase < brightness.
REQ-025 Leading-zero blank: digit i blanked when blank_lz=1, i>0, and nibbles i..DIGITS-1 all zero; digit 0 never LZ-blanked.
REQ-026 Blink: frame counter 0..BLINK_FRAMES-1 toggles blink_phase on wrap; blink_mask digits blank while blink_phase=1.
REQ-027 Blanked digit or PWM off-phase: display_en all ones, display_data 8'hFF.
REQ-028 Outputs lag internal counter state by exactly one clk cycle.
REQ-029 digit_mask, blink_mask, blank_lz, brightness sampled live each cycle, not buffered.

Reset
REQ-030 clr_n low: counters, digit index, blink_phase, active, pending cleared; upd_pending=0, frame_done=0, display_en all ones, display_data 8'hFF.
REQ-031 Reset mid-frame discards pending load; first slot after release is digit 0, tick 0.

Structure
REQ-032 Package seg_pkg holds hex-to-segment table (16 x 8-bit, active-low) and SEG_BLANK = 8'hFF.
REQ-033 Sub-module seg_hex_decode: combinational nibble+dp to 8-bit pattern using seg_pkg.

Verification (DIGITS=8, SCAN_DIV=16, BRIGHT_W=2, BLINK_FRAMES=2)
REQ-034 Reset release, brightness=3 -> display_en 8'hFF, display_data 8'hFF; first frame_done 128 cycles after release.
REQ-035 load data=32'h1234_ABCD mid-frame -> upd_pending=1, old digits until boundary; next frame digit 0 = 'D' pattern.
REQ-036 load exactly on frame_done cycle -> new value visible next frame, upd_pending never 1.
REQ-037 data=32'h0000_0070, blank_lz=1 -> digits 7..2 blank, digit 1='7', digit 0='0'; data=0 -> only digit 0 lit.
REQ-038 brightness=1 -> each digit enabled 4 of 16 slot cycles; brightness=0 -> display_en always 8'hFF.
REQ-039 blink_mask=8'h01 -> digit 0 lit frames 0-1, blank frames 2-3, repeating; other digits steady.
